// File: rtl/debounce_events.sv
// Multi-channel pin conditioner: synchroniser, debounce, press/release/long-press
// event pulses, sticky pending flags and a masked, registered interrupt.
module debounce_events #(
   parameter int    WIDTH         = 2,
   parameter string POLARITY      = "LOW",
   parameter int    SYNC_STAGES   = 2,
   parameter int    TIMEOUT       = 50000,
   parameter int    TIMEOUT_WIDTH = 16,
   parameter int    LONG_TIMEOUT  = 50000000,
   parameter int    LONG_WIDTH    = 26
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     data_in,
   output logic [WIDTH-1:0]     data_out,
   output logic [WIDTH-1:0]     press_pulse,
   output logic [WIDTH-1:0]     release_pulse,
   output logic [WIDTH-1:0]     long_pulse,
   output logic [3*WIDTH-1:0]   pending,
   input  logic [WIDTH-1:0]     irq_mask,
   input  logic [WIDTH-1:0]     ack,
   output logic                 irq
);
   localparam bit ACTIVE_LOW = (POLARITY == "LOW");
   localparam bit LONG_EN    = (LONG_TIMEOUT > 0);
   localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST  = TIMEOUT_WIDTH'(TIMEOUT - 1);
   localparam logic [LONG_WIDTH-1:0]    HOLD_MAX  = LONG_WIDTH'(LONG_TIMEOUT);
   localparam logic [LONG_WIDTH-1:0]    HOLD_LAST = LONG_WIDTH'(LONG_EN ? LONG_TIMEOUT - 1 : 0);

   logic [WIDTH-1:0]         sync_p [SYNC_STAGES];
   logic [WIDTH-1:0]         norm;
   logic [WIDTH-1:0]         db, db_next;
   logic [TIMEOUT_WIDTH-1:0] cnt [WIDTH];
   logic [TIMEOUT_WIDTH-1:0] cnt_next [WIDTH];
   logic [LONG_WIDTH-1:0]    hcnt [WIDTH];
   logic [LONG_WIDTH-1:0]    hcnt_next [WIDTH];
   logic [WIDTH-1:0]         press_next, release_next, long_next;
   logic [WIDTH-1:0]         pend_press, pend_release, pend_long;

   // Synchroniser chain; reset parks it at the inactive pin level so no event follows reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= {WIDTH{ACTIVE_LOW}};
      end else begin
         sync_p[0] <= data_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
      end
   end

   assign norm = ACTIVE_LOW ? ~sync_p[SYNC_STAGES-1] : sync_p[SYNC_STAGES-1];

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         db_next[i]  = db[i];
         cnt_next[i] = '0;
         if (norm[i] != db[i]) begin
            if (cnt[i] == CNT_LAST) db_next[i] = norm[i];
            else                    cnt_next[i] = cnt[i] + TIMEOUT_WIDTH'(1);
         end
      end
   end

   assign press_next   = db_next & ~db;
   assign release_next = ~db_next & db;

   // The press edge itself is hold cycle 0, so long_pulse lands LONG_TIMEOUT edges after data_out rises.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         hcnt_next[i] = '0;
         long_next[i] = 1'b0;
         if (LONG_EN && db_next[i] && db[i]) begin
            if (hcnt[i] < HOLD_MAX) begin
               hcnt_next[i] = hcnt[i] + LONG_WIDTH'(1);
               long_next[i] = (hcnt[i] == HOLD_LAST);
            end else begin
               hcnt_next[i] = hcnt[i];
            end
         end
      end
   end

   // Event, pending and interrupt registers; a set beats a same-cycle ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         db            <= '0;
         press_pulse   <= '0;
         release_pulse <= '0;
         long_pulse    <= '0;
         pend_press    <= '0;
         pend_release  <= '0;
         pend_long     <= '0;
         irq           <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i]  <= '0;
            hcnt[i] <= '0;
         end
      end else begin
         db            <= db_next;
         press_pulse   <= press_next;
         release_pulse <= release_next;
         long_pulse    <= long_next;
         pend_press    <= (pend_press & ~ack) | press_next;
         pend_release  <= (pend_release & ~ack) | release_next;
         pend_long     <= (pend_long & ~ack) | long_next;
         irq           <= |(irq_mask & (pend_press | pend_release | pend_long));
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i]  <= cnt_next[i];
            hcnt[i] <= hcnt_next[i];
         end
      end
   end

   assign data_out = db;
   assign pending  = {pend_long, pend_release, pend_press};

endmodule

// File: tb/tb_debounce_events.sv
// Bench for debounce_events: reset/press vector table, directed corner cases and a
// randomized run checked every cycle against a window-based reference model.
module tb_debounce_events;
   localparam int W  = 4;
   localparam int S  = 2;
   localparam int T  = 8;
   localparam int LT = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  data_in;
   logic [W-1:0]  data_out, press_pulse, release_pulse, long_pulse;
   logic [3*W-1:0] pending;
   logic [W-1:0]  irq_mask, ack;
   logic          irq;

   always #5 clk = ~clk;

   debounce_events #(
      .WIDTH(W), .POLARITY("LOW"), .SYNC_STAGES(S), .TIMEOUT(T),
      .TIMEOUT_WIDTH(4), .LONG_TIMEOUT(LT), .LONG_WIDTH(5)
   ) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_out(data_out),
      .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse),
      .pending(pending), .irq_mask(irq_mask), .ack(ack), .irq(irq)
   );

   typedef struct packed {
      logic [3:0]  pin;
      logic [3:0]  out;
      logic [3:0]  press;
      logic [11:0] pend;
      logic        irq;
   } vec_t;

   int checks = 0;
   int passes = 0;
   int cyc    = 0;
   logic [W-1:0] pin_v, mask_v;

   // Reference model: a level is accepted once the last T debouncer samples all disagree with it.
   logic [W-1:0] m_pipe [S];
   logic [T-1:0] m_win [W];
   logic [W-1:0] m_db, m_press, m_rel, m_long, m_pp, m_pr, m_pl;
   logic         m_irq;
   int           m_held [W];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, exp);
   endtask

   task automatic model_update(input logic rst, input logic [W-1:0] pin, input logic [W-1:0] ackv,
                               input logic [W-1:0] maskv);
      logic [W-1:0] nu, old;
      if (rst) begin
         for (int s = 0; s < S; s++) m_pipe[s] = '0;
         for (int i = 0; i < W; i++) begin m_win[i] = '0; m_held[i] = 0; end
         m_db = '0; m_press = '0; m_rel = '0; m_long = '0;
         m_pp = '0; m_pr = '0; m_pl = '0; m_irq = 1'b0;
      end else begin
         nu    = m_pipe[S-1];
         old   = m_db;
         m_irq = |(maskv & (m_pp | m_pr | m_pl));
         for (int s = S-1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
         m_pipe[0] = ~pin;
         for (int i = 0; i < W; i++) begin
            m_win[i] = {m_win[i][T-2:0], nu[i]};
            if (m_win[i] == {T{~old[i]}}) m_db[i] = ~old[i];
            m_press[i] = m_db[i] & ~old[i];
            m_rel[i]   = ~m_db[i] & old[i];
            m_long[i]  = 1'b0;
            if (!m_db[i] || !old[i]) m_held[i] = 0;
            else if (m_held[i] < LT) begin
               m_held[i]++;
               m_long[i] = (m_held[i] == LT);
            end
         end
         m_pp = (m_pp & ~ackv) | m_press;
         m_pr = (m_pr & ~ackv) | m_rel;
         m_pl = (m_pl & ~ackv) | m_long;
      end
   endtask

   task automatic step(input logic rst, input logic [W-1:0] ackv);
      reset    = rst;
      data_in  = pin_v;
      ack      = ackv;
      irq_mask = mask_v;
      @(posedge clk);
      model_update(rst, pin_v, ackv, mask_v);
      #1;
      cyc++;
      check("model", 64'({data_out, press_pulse, release_pulse, long_pulse, pending, irq}),
            64'({m_db, m_press, m_rel, m_long, m_pl, m_pr, m_pp, m_irq}));
   endtask

   vec_t tbl [12];
   int   rise_k, long_k, long_cnt, rel_k;
   int   hold_left [W];
   logic seen;
   logic [W-1:0] ackr;
   logic rstr;

   initial begin
      for (int k = 0; k < 9; k++) tbl[k] = '{4'hE, 4'h0, 4'h0, 12'h000, 1'b0};
      tbl[9]  = '{4'hE, 4'h1, 4'h1, 12'h001, 1'b0};
      tbl[10] = '{4'hE, 4'h1, 4'h0, 12'h001, 1'b1};
      tbl[11] = '{4'hE, 4'h1, 4'h0, 12'h001, 1'b1};

      pin_v  = 4'hF;
      mask_v = 4'hF;
      repeat (3) step(1'b1, 4'h0);
      for (int k = 0; k < 50; k++) begin
         step(1'b0, 4'h0);
         check("idle", 64'({data_out, press_pulse, release_pulse, long_pulse, pending, irq}), 64'd0);
      end

      for (int k = 0; k < 12; k++) begin
         pin_v = tbl[k].pin;
         step(1'b0, 4'h0);
         check("press_out", 64'(data_out), 64'(tbl[k].out));
         check("press_pulse", 64'(press_pulse), 64'(tbl[k].press));
         check("press_pend", 64'(pending), 64'(tbl[k].pend));
         check("press_irq", 64'(irq), 64'(tbl[k].irq));
      end

      for (int k = 0; k < 27; k++) begin
         pin_v = (k < 7 || (k >= 8 && k < 15)) ? 4'hC : 4'hE;
         step(1'b0, 4'h0);
         check("glitch", 64'({data_out[1], press_pulse[1], release_pulse[1],
                              pending[9], pending[5], pending[1]}), 64'd0);
      end

      pin_v = 4'hA; rise_k = -1; long_k = -1; long_cnt = 0;
      for (int k = 1; k <= 40; k++) begin
         step(1'b0, 4'h0);
         if (press_pulse[2] && rise_k < 0) rise_k = k;
         if (long_pulse[2]) begin long_cnt++; long_k = k; end
      end
      check("long_rise_edge", 64'(rise_k), 64'd10);
      check("long_count", 64'(long_cnt), 64'd1);
      check("long_delay", 64'(long_k - rise_k), 64'd20);
      check("long_pend", 64'(pending[10]), 64'd1);
      pin_v = 4'hE; rel_k = -1;
      for (int k = 1; k <= 15; k++) begin
         step(1'b0, 4'h0);
         if (release_pulse[2] && rel_k < 0) rel_k = k;
      end
      check("release_edge", 64'(rel_k), 64'd10);
      check("release_pend", 64'(pending[6]), 64'd1);

      step(1'b0, 4'hF);
      step(1'b0, 4'h0);
      step(1'b0, 4'h0);
      check("ackall_pend", 64'(pending), 64'd0);
      check("ackall_irq", 64'(irq), 64'd0);
      pin_v = 4'h6;
      for (int k = 1; k <= 9; k++) step(1'b0, 4'h0);
      step(1'b0, 4'h8);
      check("race_pulse", 64'(press_pulse[3]), 64'd1);
      check("race_pend", 64'(pending[3]), 64'd1);
      step(1'b0, 4'h0);
      check("race_hold", 64'(pending[3]), 64'd1);
      step(1'b0, 4'h8);
      check("ack_clear", 64'({pending[11], pending[7], pending[3]}), 64'd0);
      step(1'b0, 4'h0);
      check("ack_irq", 64'(irq), 64'd0);

      mask_v = 4'h0; pin_v = 4'h4; seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step(1'b0, 4'h0);
         if (irq) seen = 1'b1;
      end
      check("mask_irq", 64'(seen), 64'd0);
      check("mask_pend", 64'(pending[1]), 64'd1);
      mask_v = 4'hF;
      step(1'b0, 4'h0);
      check("unmask_irq", 64'(irq), 64'd1);

      pin_v = 4'h6;
      repeat (7) step(1'b0, 4'h0);
      step(1'b1, 4'h0);
      check("midreset", 64'({data_out, press_pulse, release_pulse, long_pulse, pending, irq}), 64'd0);
      seen = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         step(1'b0, 4'h0);
         if (data_out != 4'h0 || press_pulse != 4'h0) seen = 1'b1;
      end
      check("restart_early", 64'(seen), 64'd0);
      step(1'b0, 4'h0);
      check("restart_out", 64'(data_out), 64'h9);
      check("restart_press", 64'(press_pulse), 64'h9);

      for (int i = 0; i < W; i++) hold_left[i] = 0;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < W; i++) begin
            if (hold_left[i] == 0) begin
               pin_v[i]     = 1'($urandom_range(0, 1));
               hold_left[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7))
                                                           : int'($urandom_range(8, 40));
            end else begin
               hold_left[i]--;
            end
         end
         if ($urandom_range(0, 15) == 0) mask_v = 4'($urandom);
         ackr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
         rstr = ($urandom_range(0, 599) == 0);
         step(rstr, ackr);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
